fir_coef_bank: RTL
==================

Name: fir_coef_bank

Overview:
Double-buffered coefficient store that sits directly upstream of the FIR core and drives its coef_flat and clear_state inputs. Control logic writes taps one at a time into a shadow set, then issues commit. The block transfers shadow to active atomically on a sample boundary, defined by sample_tick, which is the same strobe that drives the core's en. Optionally it then flushes the core's delay line for exactly one sample.

Parameters:
COEFW, 16, coefficient width (signed, matches core)
NTAPS, 129, number of taps (matches core)
ADDRW, 8, tap address width; NTAPS <= 2**ADDRW
CLEAR_ON_SWAP, 1, 1 = assert clear_state for one sample after each swap; 0 = no clear

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wr_en  in  1  tap write strobe
wr_addr  in  ADDRW  tap index 0..NTAPS-1
wr_data  in  COEFW  signed coefficient
commit  in  1  request shadow->active transfer (single-cycle pulse)
sample_tick  in  1  sample boundary strobe (same signal as the core's en)
coef_flat  out  NTAPS*COEFW  active coefficient set, tap i at [i*COEFW +: COEFW]
clear_state  out  1  core state-clear request
busy  out  1  commit accepted, transfer/clear not yet complete
swap_done  out  1  one-cycle pulse at completion of the commit sequence
wr_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (async, immediate): shadow and active sets = 0; coef_flat = 0; clear_state = 0; busy = 0; swap_done = 0; wr_err = 0; FSM = IDLE. Any pending commit is discarded.
- Storage: shadow register array and active register array. coef_flat is driven directly from the active registers, with no combinational path from the write port.
- Write acceptance: when wr_en = 1, wr_addr < NTAPS and busy = 0, shadow[wr_addr] <= wr_data at that edge. coef_flat is unaffected.
- Write rejection: when wr_en = 1 and (wr_addr >= NTAPS or busy = 1), the write is dropped and wr_err = 1 on the next cycle, for one cycle.
- The shadow set is never cleared by a swap. After a swap, shadow equals active, so partial updates (rewriting a subset of taps) are valid.
- FSM states IDLE, PENDING, CLEARING:
  - IDLE: busy = 0. If commit = 1, go to PENDING and set busy = 1 from the next cycle. A sample_tick in the same cycle as commit does not trigger the swap.
  - PENDING: wait for sample_tick. The core consumes that tick with the old coefficients. At that edge: active <= shadow, so the new coef_flat is visible from the next cycle.
    - CLEAR_ON_SWAP = 1: go to CLEARING.
    - CLEAR_ON_SWAP = 0: go to IDLE, swap_done pulses the next cycle, busy drops the next cycle.
  - CLEARING: clear_state = 1 (registered) from the cycle after the swap edge. It stays high through and including the next sample_tick, so the core clears on exactly one en. On that tick's edge: clear_state <= 0, swap_done pulses one cycle, busy <= 0, go to IDLE.
- commit while busy = 1: ignored, no error flag.
- commit and an accepted wr_en in the same IDLE cycle: the write lands in shadow and is included in the swap.
- sample_tick while IDLE: no effect.
- Total latency from commit to new coefficients equals the wait to the first sample_tick strictly after the commit cycle, plus 1 cycle.

Test Plan:
- Reset: assert rst mid-run -> coef_flat = 0, busy = clear_state = swap_done = wr_err = 0 immediately, without a clock edge.
- Basic load: write tap0 = 0x4000, tap1 = 0x2000, tap128 = 0x8001, then commit, then sample_tick 5 cycles later -> coef_flat unchanged through the tick cycle; next cycle coef_flat[15:0] = 0x4000, [31:16] = 0x2000, [2063:2048] = 0x8001; clear_state high until and including the following tick; swap_done pulse one cycle after that tick; busy low afterwards.
- Rejected writes: wr_addr = 129 in IDLE -> wr_err one-cycle pulse, shadow unchanged. Write tap0 = 0x1111 while busy -> wr_err pulse; a later commit shows tap0 still 0x4000.
- Commit coincident with sample_tick -> no swap on that tick; swap on the next tick.
- Partial update: after one swap, rewrite only tap5 = 0x0100 and commit -> all other taps retain their previous values, tap5 = 0x0100.
- CLEAR_ON_SWAP = 0: commit, then tick -> clear_state never asserts; swap_done and busy-low one cycle after the tick. Async reset while PENDING -> commit lost, coef_flat = 0.

Source files
------------

// File: rtl/fir_coef_bank.sv
// Double-buffered FIR coefficient store: taps are written into a shadow set and moved to the active set on a sample boundary.
// Latency: new coef_flat appears 1 cycle after the first sample_tick strictly after commit; optional clear_state lasts one sample.
// Backpressure: busy blocks writes and commits until the swap (and clear) completes; rejected writes pulse wr_err.
module fir_coef_bank #(
    parameter int COEFW         = 16,
    parameter int NTAPS         = 129,
    parameter int ADDRW         = 8,
    parameter bit CLEAR_ON_SWAP = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDRW-1:0]       wr_addr,
    input  logic [COEFW-1:0]       wr_data,
    input  logic                   commit,
    input  logic                   sample_tick,
    output logic [NTAPS*COEFW-1:0] coef_flat,
    output logic                   clear_state,
    output logic                   busy,
    output logic                   swap_done,
    output logic                   wr_err
);

    typedef enum logic [1:0] {IDLE, PENDING, CLEARING} state_t;

    localparam logic [ADDRW:0] NTAPS_W = NTAPS[ADDRW:0];

    state_t           state;
    logic [COEFW-1:0] shadow [NTAPS];
    logic [COEFW-1:0] active [NTAPS];
    logic             addr_ok;

    assign addr_ok = ({1'b0, wr_addr} < NTAPS_W);

    genvar g;
    for (g = 0; g < NTAPS; g++) begin : g_flat
        assign coef_flat[g*COEFW +: COEFW] = active[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            clear_state <= 1'b0;
            swap_done   <= 1'b0;
            wr_err      <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            swap_done <= 1'b0;
            wr_err    <= 1'b0;

            // Shadow is frozen while a commit is outstanding so the swap sees a stable set.
            if (wr_en) begin
                if (addr_ok && !busy) begin
                    shadow[wr_addr] <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (commit) begin
                        state <= PENDING;
                        busy  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (sample_tick) begin
                        for (int i = 0; i < NTAPS; i++) begin
                            active[i] <= shadow[i];
                        end
                        if (CLEAR_ON_SWAP) begin
                            state       <= CLEARING;
                            clear_state <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            swap_done <= 1'b1;
                        end
                    end
                end
                CLEARING: begin
                    // Held through exactly one en so the core flushes on a single sample.
                    if (sample_tick) begin
                        state       <= IDLE;
                        clear_state <= 1'b0;
                        busy        <= 1'b0;
                        swap_done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
